// File: rtl/lb_window.sv
// Line buffer: fills one image line from multi-pixel writes, then serves windowed reads until released.
// Optional macro LB_WINDOW_WRAP_EN: window pixels past the line end wrap to the line start instead of reading zero.
module lb_window #(
    parameter int PIX_W  = 8,
    parameter int LINE_W = 28,
    parameter int WR_PIX = 4,
    parameter int RD_PIX = 3,
    parameter int AW     = $clog2(LINE_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_PIX*PIX_W-1:0]   wr_data,
    output logic                      wr_ready,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    output logic [RD_PIX*PIX_W-1:0]   rd_data,
    output logic                      rd_valid,
    input  logic                      rel,
    output logic                      full,
    output logic [15:0]               line_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Extra index bits so rd_addr + k never overflows before the range test.
    localparam int            IW       = AW + 2;
    localparam logic [IW-1:0] LINE_W_I = IW'(LINE_W);
    localparam logic [AW-1:0] LAST_PTR = AW'(LINE_W - WR_PIX);
    localparam logic [AW-1:0] PTR_STEP = AW'(WR_PIX);

    state_t                     state;
    logic [AW-1:0]              wr_ptr;
    logic [PIX_W-1:0]           mem [LINE_W];
    logic [RD_PIX*PIX_W-1:0]    window;
    logic                       wr_accept;

    assign full      = (state == HOLD);
    assign wr_ready  = !full;
    assign wr_accept = wr_en && (state == FILL);

    function automatic logic [PIX_W-1:0] pix_at(input logic [IW-1:0] idx);
        logic [PIX_W-1:0] pix;
        pix = '0;
        if (idx < LINE_W_I) begin
            pix = mem[idx[AW-1:0]];
        end
`ifdef LB_WINDOW_WRAP_EN
        else begin
            pix = mem[AW'(idx % LINE_W_I)];
        end
`endif
        return pix;
    endfunction

    always_comb begin
        window = '0;
        for (int k = 0; k < RD_PIX; k++) begin
            window[k*PIX_W +: PIX_W] = pix_at(IW'(rd_addr) + IW'(k));
        end
    end

    // Pixel storage has no reset; a partial line is simply overwritten on the next fill.
    always_ff @(posedge clk) begin
        if (rst && wr_accept) begin
            for (int j = 0; j < WR_PIX; j++) begin
                mem[wr_ptr + AW'(j)] <= wr_data[j*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FILL;
            wr_ptr   <= '0;
            line_cnt <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (wr_en) begin
                        if (wr_ptr == LAST_PTR) begin
                            wr_ptr   <= '0;
                            line_cnt <= line_cnt + 16'd1;
                            state    <= HOLD;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_STEP;
                        end
                    end
                end
                HOLD: begin
                    // A read in the release cycle still sees the line being released.
                    if (rd_en) begin
                        rd_data  <= window;
                        rd_valid <= 1'b1;
                    end
                    if (rel) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
